// File: rtl/multi_issue_control_unit.sv
// Multi-issue decode stage: ISSUE_WIDTH opcodes per group -> one-hot control vectors, 2-entry elastic queue.
// Optional build macro DECODE_ILLEGAL_EN: flag opcode 0 on a valid lane as illegal instead of decoding it as NOP.

module mic_lane_decode (
   input  logic        lane_valid,
   input  logic [3:0]  opcode,
   output logic        valid,
   output logic [15:0] ctrl,
   output logic        illegal,
   output logic        ubranch
);
   always_comb begin
      ctrl    = '0;
      illegal = 1'b0;
      valid   = lane_valid;
      case (opcode)
         4'h0: begin
`ifdef DECODE_ILLEGAL_EN
            illegal = lane_valid;
            valid   = 1'b0;
`else
            ctrl    = '0;
`endif
         end
         4'h1: ctrl = 16'h4001;   // add
         4'h2: ctrl = 16'h4002;   // sub
         4'h3: ctrl = 16'h4004;   // mul
         4'h4: ctrl = 16'h4008;   // ld
         4'h5: ctrl = 16'h0010;   // st
         4'h6: ctrl = 16'h0020;   // cmp
         4'h7: ctrl = 16'h4040;   // mov
         4'h8: ctrl = 16'h4080;   // or
         4'h9: ctrl = 16'h4100;   // and
         4'hA: ctrl = 16'h4200;   // not
         4'hB: ctrl = 16'h4400;   // lsl
         4'hC: ctrl = 16'h8000;   // ubranch
         4'hD: ctrl = 16'h4800;   // lsr
         4'hE: ctrl = 16'h1000;   // beq
         4'hF: ctrl = 16'h2000;   // bgt
      endcase
      if (!lane_valid) ctrl = '0;
   end

   assign ubranch = lane_valid && (opcode == 4'hC);
endmodule

module multi_issue_control_unit #(
   parameter int ISSUE_WIDTH = 2,
   parameter int CNT_W       = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ISSUE_WIDTH-1:0]    in_lane_valid,
   input  logic [4*ISSUE_WIDTH-1:0]  in_opcode,
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ISSUE_WIDTH-1:0]    out_lane_valid,
   output logic [16*ISSUE_WIDTH-1:0] out_ctrl,
   output logic [ISSUE_WIDTH-1:0]    out_illegal,
   output logic [CNT_W-1:0]          issued_count
);
   typedef struct packed {
      logic [ISSUE_WIDTH-1:0]       lv;
      logic [ISSUE_WIDTH-1:0][15:0] ctrl;
      logic [ISSUE_WIDTH-1:0]       ill;
   } grp_t;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   logic [ISSUE_WIDTH-1:0]       dec_valid, dec_ill, dec_br;
   logic [ISSUE_WIDTH-1:0][15:0] dec_ctrl;
   logic [ISSUE_WIDTH-1:0]       sq_lv, sq_ill;
   logic [ISSUE_WIDTH-1:0][15:0] sq_ctrl;
   grp_t                         dec_grp, head, tail;
   state_t                       state, state_nxt;
   logic                         in_fire, out_fire;
   logic                         ld_head, ld_tail, adv;

   for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_lane
      mic_lane_decode u_dec (
         .lane_valid (in_lane_valid[i]),
         .opcode     (in_opcode[4*i +: 4]),
         .valid      (dec_valid[i]),
         .ctrl       (dec_ctrl[i]),
         .illegal    (dec_ill[i]),
         .ubranch    (dec_br[i])
      );
   end

   // Everything younger than the oldest unconditional branch is discarded.
   always_comb begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         sq_lv[i]   = dec_valid[i] & ~seen;
         sq_ill[i]  = dec_ill[i] & ~seen;
         sq_ctrl[i] = seen ? 16'h0 : dec_ctrl[i];
         seen       = seen | dec_br[i];
      end
   end

   assign dec_grp = '{lv: sq_lv, ctrl: sq_ctrl, ill: sq_ill};

   assign out_valid = (state != EMPTY);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= EMPTY;
         in_ready <= 1'b1;
      end else begin
         state    <= state_nxt;
         in_ready <= (state_nxt != FULL);
      end
   end

   always_comb begin
      state_nxt = state;
      if (flush) state_nxt = EMPTY;
      else begin
         case (state)
            EMPTY: if (in_fire) state_nxt = ONE;
            ONE: begin
               if (in_fire && !out_fire)      state_nxt = FULL;
               else if (out_fire && !in_fire) state_nxt = EMPTY;
            end
            FULL:    if (out_fire) state_nxt = ONE;
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_comb begin
      ld_head = 1'b0;
      ld_tail = 1'b0;
      adv     = 1'b0;
      if (!flush) begin
         case (state)
            EMPTY: ld_head = in_fire;
            ONE: begin
               ld_head = in_fire & out_fire;
               ld_tail = in_fire & ~out_fire;
            end
            FULL:    adv = out_fire;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (ld_head)  head <= dec_grp;
         else if (adv) head <= tail;
         if (ld_tail)  tail <= dec_grp;
      end
   end

   function automatic logic [CNT_W-1:0] popcnt(input logic [ISSUE_WIDTH-1:0] v);
      popcnt = '0;
      for (int i = 0; i < ISSUE_WIDTH; i++) popcnt = popcnt + CNT_W'(v[i]);
   endfunction

   always_ff @(posedge clk) begin
      if (reset)                  issued_count <= '0;
      else if (out_fire && !flush) issued_count <= issued_count + popcnt(head.lv);
   end

   assign out_lane_valid = head.lv;
   assign out_ctrl       = head.ctrl;
   assign out_illegal    = head.ill;
endmodule

// File: tb/tb_multi_issue_control_unit.sv
// Bench for multi_issue_control_unit: directed scenarios plus random traffic vs a queue-based model.
module tb_multi_issue_control_unit;
   localparam int W  = 2;
   localparam int CW = 4;
`ifdef DECODE_ILLEGAL_EN
   localparam bit ILL = 1'b1;
`else
   localparam bit ILL = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset, in_valid, in_ready, flush, out_valid, out_ready;
   logic [W-1:0]    in_lane_valid, out_lane_valid, out_illegal;
   logic [4*W-1:0]  in_opcode;
   logic [16*W-1:0] out_ctrl;
   logic [CW-1:0]   issued_count;

   multi_issue_control_unit #(.ISSUE_WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_lane_valid(in_lane_valid), .in_opcode(in_opcode), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_lane_valid(out_lane_valid),
      .out_ctrl(out_ctrl), .out_illegal(out_illegal), .issued_count(issued_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0]    lv;
      logic [16*W-1:0] ctrl;
      logic [W-1:0]    ill;
   } grp_t;

   grp_t          q[$];
   logic [CW-1:0] m_cnt = '0;
   int            n_cmp = 0, n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Op bits 0..10 hold opcodes 1..B, bits 11..13 hold D..F, ubranch is bit 15, wb is bit 14.
   function automatic logic [15:0] op_bits(input logic [3:0] op);
      logic [15:0] r;
      r = '0;
      if (op == 4'hC)      r[15] = 1'b1;
      else if (op >= 4'hD) r[op - 4'd2] = 1'b1;
      else if (op != 4'h0) r[op - 4'd1] = 1'b1;
      if (op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hD}) r[14] = 1'b1;
      return r;
   endfunction

   function automatic grp_t decode(input logic [W-1:0] v, input logic [4*W-1:0] ops);
      grp_t g;
      bit   seen;
      logic [3:0] op;
      g = '0;
      seen = 1'b0;
      for (int i = 0; i < W; i++) begin
         op = ops[4*i +: 4];
         if (seen || !v[i]) continue;
         if (op == 4'h0 && ILL) g.ill[i] = 1'b1;
         else begin
            g.lv[i] = 1'b1;
            g.ctrl[16*i +: 16] = op_bits(op);
            if (op == 4'hC) seen = 1'b1;
         end
      end
      return g;
   endfunction

   task automatic model_update();
      bit inf, outf;
      if (reset) begin
         q.delete();
         m_cnt = '0;
      end else if (flush) begin
         q.delete();
      end else begin
         inf  = in_valid && (q.size() < 2);
         outf = (q.size() > 0) && out_ready;
         if (outf) begin
            m_cnt = m_cnt + CW'($countones(q[0].lv));
            void'(q.pop_front());
         end
         if (inf) q.push_back(decode(in_lane_valid, in_opcode));
      end
   endtask

   task automatic cmp_model();
      chk("m_in_ready", in_ready, q.size() < 2);
      chk("m_out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
         chk("m_lane_valid", out_lane_valid, q[0].lv);
         chk("m_ctrl", out_ctrl, q[0].ctrl);
         chk("m_illegal", out_illegal, q[0].ill);
      end
      chk("m_count", issued_count, m_cnt);
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      cmp_model();
   endtask

   task automatic drive(input logic v, input logic [W-1:0] lv, input logic [4*W-1:0] ops);
      in_valid = v;
      in_lane_valid = lv;
      in_opcode = ops;
   endtask

   initial begin
      logic [4*W-1:0] ops;
      int r;
      reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, '0, '0);
      step();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_count", issued_count, 0);
      reset = 1'b0;

      // add/mul pair
      drive(1'b1, 2'b11, 8'h31); out_ready = 1'b1;
      step();
      chk("t1_ctrl", out_ctrl, 32'h4004_4001);
      chk("t1_lv", out_lane_valid, 2'b11);
      drive(1'b0, '0, '0);
      step();
      chk("t1_count", issued_count, 2);

      // back-pressure with three groups
      out_ready = 1'b0;
      drive(1'b1, 2'b11, 8'h12); step();
      drive(1'b1, 2'b11, 8'h45); step();
      chk("t2_full_rdy", in_ready, 0);
      drive(1'b1, 2'b11, 8'h67); step();
      chk("t2_held_rdy", in_ready, 0);
      chk("t2_head_a", out_ctrl, 32'h4001_4002);
      out_ready = 1'b1;
      step();
      chk("t2_head_b", out_ctrl, 32'h4008_0010);
      step();
      chk("t2_head_c", out_ctrl, 32'h0020_4040);
      drive(1'b0, '0, '0);
      step();
      chk("t2_count", issued_count, 8);
      chk("t2_empty", out_valid, 0);

      // ubranch in lane 0 squashes lane 1
      drive(1'b1, 2'b11, 8'h1C); step();
      chk("t3_ctrl", out_ctrl, 32'h0000_8000);
      chk("t3_lv", out_lane_valid, 2'b01);
      drive(1'b0, '0, '0); step();
      chk("t3_count", issued_count, 9);

      // flush a full queue while a group is offered
      out_ready = 1'b0;
      drive(1'b1, 2'b11, 8'h11); step(); step();
      chk("t4_full", in_ready, 0);
      flush = 1'b1; drive(1'b1, 2'b11, 8'h99); step();
      flush = 1'b0; drive(1'b0, '0, '0);
      chk("t4_valid", out_valid, 0);
      chk("t4_rdy", in_ready, 1);
      out_ready = 1'b1; step();
      chk("t4_gone", out_valid, 0);
      chk("t4_count", issued_count, 9);

      // counter wrap: 9 + 4*2 = 17 -> 1
      for (int k = 0; k < 4; k++) begin drive(1'b1, 2'b11, 8'h11); step(); end
      drive(1'b0, '0, '0); step();
      chk("t5_wrap", issued_count, 1);
      out_ready = 1'b0; drive(1'b1, 2'b11, 8'h23); step();
      reset = 1'b1; flush = 1'b1; step();
      reset = 1'b0; flush = 1'b0; drive(1'b0, '0, '0);
      chk("t5_valid", out_valid, 0);
      chk("t5_lv", out_lane_valid, 0);
      chk("t5_ctrl", out_ctrl, 0);
      chk("t5_ill", out_illegal, 0);
      chk("t5_count", issued_count, 0);
      chk("t5_rdy", in_ready, 1);

      // opcode 0 on lane 0
      out_ready = 1'b1; drive(1'b1, 2'b01, 8'h00); step();
      chk("t6_ill", out_illegal, ILL ? 2'b01 : 2'b00);
      chk("t6_lv", out_lane_valid, ILL ? 2'b00 : 2'b01);
      chk("t6_ctrl", out_ctrl, 0);
      drive(1'b0, '0, '0); step();
      chk("t6_count", issued_count, ILL ? 0 : 1);

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         reset     = ($urandom_range(0, 199) == 0);
         flush     = ($urandom_range(0, 15) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < W; i++) begin
            r = $urandom_range(0, 5);
            ops[4*i +: 4] = (r == 0) ? 4'h0 : (r == 1) ? 4'hC : 4'($urandom);
         end
         drive($urandom_range(0, 2) != 0, W'($urandom), ops);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
